fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 66 ++++++
 tb/tb_fetch_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: two-cycle fetch FSM (clk, rst, start/halt/jump control in; pc to imem, instr_in back; ir/ir_pc/ir_valid with ir_ready handshake; busy; saturating issued count)
module fetch_sequencer #(
  parameter bit LOOP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       halt,
  input  logic       jump_en,
  input  logic [1:0] jump_addr,
  output logic [1:0] pc,
  input  logic [2:0] instr_in,
  output logic [2:0] ir,
  output logic [1:0] ir_pc,
  output logic       ir_valid,
  input  logic       ir_ready,
  output logic       busy,
  output logic [7:0] issued
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [1:0] pc_n;
  logic ld, xfer;
  assign xfer = state == HOLD && ir_ready;
  assign ir_valid = state == HOLD;
  assign busy = state == FETCH || state == HOLD;
  always_comb begin
    state_n = state;
    pc_n = pc;
    ld = 1'b0;
    case (state)
      IDLE: state_n = start ? FETCH : IDLE;
      FETCH: begin
        ld = !jump_en;
        pc_n = jump_en ? jump_addr : pc + 2'd1;
        state_n = jump_en ? FETCH : HOLD;
      end
      HOLD: if (xfer) begin
        pc_n = jump_en ? jump_addr : pc;
        state_n = halt ? IDLE : (!jump_en && !LOOP && ir_pc == 2'd3) ? DONE : FETCH;
      end
      DONE: begin
        pc_n = start ? 2'd0 : pc;
        state_n = start ? FETCH : DONE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      ir_pc <= '0;
      issued <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      if (ld) begin
        ir <= instr_in;
        ir_pc <= pc;
      end
      if (xfer && issued != 8'hff) issued <= issued + 8'd1;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized and directed check of fetch_sequencer (LOOP=1 and LOOP=0) against a transaction-level model
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, halt = 1'b0, jump_en = 1'b0, ir_ready = 1'b0;
  logic [1:0] jump_addr = '0;
  logic [2:0] mem [4];
  logic [1:0] pc [2], ir_pc [2];
  logic [2:0] ir [2], instr [2];
  logic ir_valid [2], busy [2];
  logic [7:0] issued [2];
  int n_cmp = 0, n_bad = 0;
  int m_st [2], m_pc [2], m_ir [2], m_irpc [2], m_iss [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    assign instr[k] = mem[pc[k]];
    fetch_sequencer #(.LOOP(k == 0)) dut (
      .clk(clk), .rst(rst), .start(start), .halt(halt), .jump_en(jump_en),
      .jump_addr(jump_addr), .pc(pc[k]), .instr_in(instr[k]), .ir(ir[k]),
      .ir_pc(ir_pc[k]), .ir_valid(ir_valid[k]), .ir_ready(ir_ready),
      .busy(busy[k]), .issued(issued[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_pc[k] = 0; m_ir[k] = 0; m_irpc[k] = 0; m_iss[k] = 0;
    end
  endtask

  // modes: 0 idle, 1 fetching, 2 holding an instruction, 3 finished (LOOP=0 only)
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit loop = (k == 0);
      if (m_st[k] == 0) begin
        if (start) m_st[k] = 1;
      end else if (m_st[k] == 1) begin
        if (jump_en) m_pc[k] = jump_addr;
        else begin
          m_ir[k] = mem[m_pc[k]];
          m_irpc[k] = m_pc[k];
          m_pc[k] = (m_pc[k] + 1) % 4;
          m_st[k] = 2;
        end
      end else if (m_st[k] == 2) begin
        if (ir_ready) begin
          m_iss[k] = (m_iss[k] < 255) ? m_iss[k] + 1 : 255;
          if (jump_en) m_pc[k] = jump_addr;
          if (halt) m_st[k] = 0;
          else if (!jump_en && !loop && m_irpc[k] == 3) m_st[k] = 3;
          else m_st[k] = 1;
        end
      end else if (start) begin
        m_pc[k] = 0;
        m_st[k] = 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("pc%0d", k), pc[k], m_pc[k]);
      chk($sformatf("ir%0d", k), ir[k], m_ir[k]);
      chk($sformatf("ir_pc%0d", k), ir_pc[k], m_irpc[k]);
      chk($sformatf("ir_valid%0d", k), ir_valid[k], m_st[k] == 2);
      chk($sformatf("busy%0d", k), busy[k], m_st[k] == 1 || m_st[k] == 2);
      chk($sformatf("issued%0d", k), issued[k], m_iss[k]);
    end
  endtask

  task automatic step(input logic s, input logic h, input logic j, input logic [1:0] ja, input logic r);
    start = s; halt = h; jump_en = j; jump_addr = ja; ir_ready = r;
    @(posedge clk);
    model_edge();
    #1 compare_all();
    @(negedge clk);
  endtask

  task automatic do_rst();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_pc", pc[k], 0);
      chk("rst_ir", ir[k], 0);
      chk("rst_ir_pc", ir_pc[k], 0);
      chk("rst_valid", ir_valid[k], 0);
      chk("rst_busy", busy[k], 0);
      chk("rst_issued", issued[k], 0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 3'(i);
    model_reset();
    #1 compare_all();
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
    chk("done_issued", issued[1], 4);
    chk("done_busy", busy[1], 0);
    chk("loop_issued", issued[0], 5);
    for (int i = 0; i < 620; i++) step(0, 0, 0, 0, 1);
    chk("sat_issued", issued[0], 255);
    do_rst();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 3, 0);
    chk("stall_pc", pc[0], 2);
    chk("stall_ir", ir[0], 1);
    step(0, 0, 0, 0, 1);
    chk("stall_issued", issued[0], 2);
    step(0, 0, 1, 3, 0);
    step(0, 0, 0, 0, 0);
    chk("jump_ir_pc", ir_pc[0], 3);
    step(0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    chk("xfer_jump_ir_pc", ir_pc[0], 1);
    step(0, 1, 0, 0, 1);
    chk("halt_busy", busy[0], 0);
    chk("halt_pc", pc[0], 2);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("resume_ir_pc", ir_pc[0], 2);
    do_rst();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) mem[$urandom_range(0, 3)] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) do_rst();
      else step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                2'($urandom_range(0, 3)), $urandom_range(0, 9) < 6);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
